gfx_shift_seq: RTL

GFX_SHIFT_SEQ -- requirements
Module: gfx_shift_seq

---
 rtl/gfx_shift_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/gfx_shift_seq.sv
// Pixel-rate sequencer driving four 4-bit universal shift registers from a one-word ROM buffer.
// Optional macro GFX_SHIFT_SEQ_UNDERRUN_CNT_EN adds a saturating 8-bit underrun counter port.
module gfx_shift_seq (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        pix_cen,
  input  logic        line_start,
  input  logic        flip,
  input  logic [15:0] rom_data,
  input  logic        rom_valid,
  input  logic        clr_err,
  output logic        rom_req,
  output logic        sr_cen,
  output logic        sr_s1,
  output logic        sr_s0,
  output logic [15:0] sr_d,
  output logic        underrun,
`ifdef GFX_SHIFT_SEQ_UNDERRUN_CNT_EN
  output logic [7:0]  underrun_cnt,
`endif
  output logic [1:0]  phase
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [15:0] buf_word;
  logic        buf_valid;
  logic        flip_q;
  logic        pending;
  logic [1:0]  mode;
  logic [15:0] interleaved;
  logic        fire;
  logic        load;
  logic        underrun_evt;
  logic        fill;
  logic        pending_nxt;

  assign rom_req = !buf_valid;
  assign {sr_s1, sr_s0} = mode;

  // An event cannot fire while sr_cen is high, otherwise two events would merge into one rising edge.
  assign fire         = !line_start && !sr_cen && (pix_cen || pending);
  assign load         = fire && (phase == 2'd0);
  assign underrun_evt = load && !buf_valid;
  assign fill         = !line_start && rom_valid && !buf_valid;

  always_comb begin
    pending_nxt = 1'b0;
    if (line_start)
      pending_nxt = 1'b0;
    else if (sr_cen)
      pending_nxt = pending || pix_cen;
    else if (pending)
      pending_nxt = pix_cen;
  end

  // Plane-interleave: register b bit n takes bit b of pixel n.
  always_comb begin
    interleaved = '0;
    for (int b = 0; b < 4; b++)
      for (int n = 0; n < 4; n++)
        interleaved[4*b+n] = buf_word[4*n+b];
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      phase   <= 2'd0;
      sr_cen  <= 1'b0;
      pending <= 1'b0;
      mode    <= MODE_HOLD;
      sr_d    <= 16'h0000;
      flip_q  <= 1'b0;
    end else begin
      sr_cen  <= fire;
      pending <= pending_nxt;
      if (line_start)
        phase <= 2'd0;
      else if (fire)
        phase <= phase + 2'd1;
      if (load) begin
        mode   <= MODE_LOAD;
        sr_d   <= buf_valid ? interleaved : 16'h0000;
        flip_q <= flip;
      end else if (fire) begin
        mode <= flip_q ? MODE_LEFT : MODE_RIGHT;
      end
    end
  end

  // A fill can only land in an empty buffer, so it never collides with a consuming load.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      buf_valid <= 1'b0;
      buf_word  <= 16'h0000;
      underrun  <= 1'b0;
    end else begin
      if (line_start)
        buf_valid <= 1'b0;
      else if (fill)
        buf_valid <= 1'b1;
      else if (load)
        buf_valid <= 1'b0;
      if (fill)
        buf_word <= rom_data;
      if (underrun_evt)
        underrun <= 1'b1;
      else if (clr_err)
        underrun <= 1'b0;
    end
  end

`ifdef GFX_SHIFT_SEQ_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)
      underrun_cnt <= 8'h00;
    else if (clr_err)
      underrun_cnt <= underrun_evt ? 8'h01 : 8'h00;
    else if (underrun_evt && underrun_cnt != 8'hFF)
      underrun_cnt <= underrun_cnt + 8'h01;
  end
`endif

endmodule
